// File: rtl/fft_sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage over ARRAY parallel complex lanes.
// Input register -> control/delay line -> output register; trivial +/-j twiddle, optional /2, flush drain.
module fft_sdf_bf_stage #(
  parameter int DATA    = 9,
  parameter int ARRAY   = 16,
  parameter int DELAY   = 16,
  parameter int TWID_EN = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid_in,
  output logic                      in_ready,
  input  logic                      mode_inv,
  input  logic                      scale_en,
  input  logic                      flush_req,
  input  logic [DATA*ARRAY-1:0]     din_re,
  input  logic [DATA*ARRAY-1:0]     din_im,
  output logic                      valid_out,
  output logic [(DATA+1)*ARRAY-1:0] dout_re,
  output logic [(DATA+1)*ARRAY-1:0] dout_im,
  output logic                      pending,
  output logic                      err_drop
);

  localparam int W  = DATA + 1;
  localparam int CW = $clog2(DELAY);

  typedef enum logic [1:0] {S_A, S_B, S_FLUSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            cur_inv, cur_scl;
  logic            v_inv, v_scl;

  logic            cnt_last, flush_go, take, beat, drop, in_b, emit, rot;

  logic                  beat_r, in_b_r, emit_r, rot_r, inv_r, scl_r;
  logic [DATA*ARRAY-1:0] x_re_r, x_im_r;

  logic signed [W-1:0] dl_re [DELAY][ARRAY];
  logic signed [W-1:0] dl_im [DELAY][ARRAY];

  logic signed [W-1:0] a_re   [ARRAY];
  logic signed [W-1:0] a_im   [ARRAY];
  logic signed [W-1:0] b_re   [ARRAY];
  logic signed [W-1:0] b_im   [ARRAY];
  logic signed [W-1:0] pre_re [ARRAY];
  logic signed [W-1:0] pre_im [ARRAY];
  logic signed [W-1:0] rot_re [ARRAY];
  logic signed [W-1:0] rot_im [ARRAY];
  logic signed [W-1:0] res_re [ARRAY];
  logic signed [W-1:0] res_im [ARRAY];
  logic signed [W-1:0] wr_re  [ARRAY];
  logic signed [W-1:0] wr_im  [ARRAY];

  // Round-half-up divide by two: (s + 1) >>> 1, with one guard bit so s = max cannot wrap.
  function automatic logic signed [W-1:0] halve(input logic signed [W-1:0] s);
    logic signed [W:0] t;
    t = {s[W-1], s} + (W+1)'(1);
    return t[W:1];
  endfunction

  // Beat qualification: flush entry takes priority over an input beat offered in the same cycle.
  always_comb begin
    cnt_last = (cnt == CW'(DELAY - 1));
    flush_go = (state == S_A) && (cnt == '0) && pending && flush_req;
    take     = valid_in && in_ready && !flush_go;
    beat     = take || (state == S_FLUSH);
    drop     = valid_in && !take;
    in_b     = (state == S_B);
    emit     = in_b || pending;
    rot      = (TWID_EN != 0) && !in_b && (cnt >= CW'(DELAY / 2));
  end

  // NOTE: every register here uses <= so each one sees the pre-edge value of its peers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_A;
      cnt      <= '0;
      pending  <= 1'b0;
      in_ready <= 1'b0;
      err_drop <= 1'b0;
      cur_inv  <= 1'b0;
      cur_scl  <= 1'b0;
      v_inv    <= 1'b0;
      v_scl    <= 1'b0;
      beat_r   <= 1'b0;
      in_b_r   <= 1'b0;
      emit_r   <= 1'b0;
      rot_r    <= 1'b0;
      inv_r    <= 1'b0;
      scl_r    <= 1'b0;
      x_re_r   <= '0;
      x_im_r   <= '0;
    end else begin
      beat_r <= beat;
      in_b_r <= in_b;
      emit_r <= beat && emit;
      rot_r  <= rot;
      // u-beats follow the frame now filling; v-beats follow the frame that produced them
      inv_r  <= in_b ? cur_inv : v_inv;
      scl_r  <= in_b ? cur_scl : v_scl;
      x_re_r <= (state == S_FLUSH) ? '0 : din_re;
      x_im_r <= (state == S_FLUSH) ? '0 : din_im;
      if (drop) err_drop <= 1'b1;

      unique case (state)
        S_A: begin
          in_ready <= !flush_go;
          if (flush_go) begin
            state <= S_FLUSH;
          end else if (take) begin
            if (cnt == '0) begin
              cur_inv <= mode_inv;
              cur_scl <= scale_en;
            end
            if (cnt_last) begin
              state   <= S_B;
              cnt     <= '0;
              pending <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_B: begin
          in_ready <= 1'b1;
          if (take) begin
            if (cnt_last) begin
              state   <= S_A;
              cnt     <= '0;
              pending <= 1'b1;
              v_inv   <= cur_inv;
              v_scl   <= cur_scl;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (cnt_last) begin
            state    <= S_A;
            cnt      <= '0;
            pending  <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_A;
      endcase
    end
  end

  // NOTE: every array element is written on every loop pass, so this block infers no latches.
  always_comb begin
    for (int l = 0; l < ARRAY; l++) begin
      a_re[l] = dl_re[DELAY-1][l];
      a_im[l] = dl_im[DELAY-1][l];
      b_re[l] = {x_re_r[l*DATA+DATA-1], x_re_r[l*DATA +: DATA]};
      b_im[l] = {x_im_r[l*DATA+DATA-1], x_im_r[l*DATA +: DATA]};

      pre_re[l] = in_b_r ? a_re[l] + b_re[l] : a_re[l];
      pre_im[l] = in_b_r ? a_im[l] + b_im[l] : a_im[l];
      wr_re[l]  = in_b_r ? a_re[l] - b_re[l] : b_re[l];
      wr_im[l]  = in_b_r ? a_im[l] - b_im[l] : b_im[l];

      if (rot_r && inv_r) begin
        rot_re[l] = -pre_im[l];
        rot_im[l] = pre_re[l];
      end else if (rot_r) begin
        rot_re[l] = pre_im[l];
        rot_im[l] = -pre_re[l];
      end else begin
        rot_re[l] = pre_re[l];
        rot_im[l] = pre_im[l];
      end

      res_re[l] = scl_r ? halve(rot_re[l]) : rot_re[l];
      res_im[l] = scl_r ? halve(rot_im[l]) : rot_im[l];
    end
  end

  // NOTE: the delay line is reset so a reset mid-frame cannot leak a stale v-half afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DELAY; i++) begin
        for (int l = 0; l < ARRAY; l++) begin
          dl_re[i][l] <= '0;
          dl_im[i][l] <= '0;
        end
      end
      valid_out <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
    end else begin
      valid_out <= emit_r;
      if (beat_r) begin
        for (int l = 0; l < ARRAY; l++) begin
          dl_re[0][l] <= wr_re[l];
          dl_im[0][l] <= wr_im[l];
        end
        for (int i = 1; i < DELAY; i++) begin
          for (int l = 0; l < ARRAY; l++) begin
            dl_re[i][l] <= dl_re[i-1][l];
            dl_im[i][l] <= dl_im[i-1][l];
          end
        end
      end
      if (emit_r) begin
        for (int l = 0; l < ARRAY; l++) begin
          dout_re[l*W +: W] <= res_re[l];
          dout_im[l*W +: W] <= res_im[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_sdf_bf_stage.sv
// Scoreboard bench for fft_sdf_bf_stage: a frame-level reference model queues expected beats with
// their due cycle, and an independent monitor pops and compares whenever valid_out is seen.
module tb_fft_sdf_bf_stage;

  localparam int DATA  = 9;
  localparam int ARRAY = 2;
  localparam int H     = 4;
  localparam int W     = DATA + 1;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  valid_in = 1'b0;
  logic                  mode_inv = 1'b0;
  logic                  scale_en = 1'b0;
  logic                  flush_req = 1'b0;
  logic [DATA*ARRAY-1:0] din_re = '0;
  logic [DATA*ARRAY-1:0] din_im = '0;
  logic                  in_ready, valid_out, pending, err_drop;
  logic [W*ARRAY-1:0]    dout_re, dout_im;

  fft_sdf_bf_stage #(.DATA(DATA), .ARRAY(ARRAY), .DELAY(H), .TWID_EN(1)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .mode_inv  (mode_inv),
    .scale_en  (scale_en),
    .flush_req (flush_req),
    .din_re    (din_re),
    .din_im    (din_im),
    .valid_out (valid_out),
    .dout_re   (dout_re),
    .dout_im   (dout_im),
    .pending   (pending),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  typedef struct {
    int stamp;
    int re0;
    int re1;
    int im0;
    int im1;
  } exp_t;

  exp_t q[$];

  // Reference model state: current frame samples, the finished v-half of the previous frame.
  int xr [ARRAY][2*H];
  int xi [ARRAY][2*H];
  int pvr[ARRAY][H];
  int pvi[ARRAY][H];
  int j = 0;
  bit pend = 0, f_inv = 0, f_scl = 0, exp_err = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int neg_sat(int v);
    return (v == -256) ? 255 : -v;
  endfunction

  function automatic int half_up(int s);
    int t;
    t = s + 1;
    return (t - (t & 1)) / 2;
  endfunction

  function automatic int sx(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic void push_exp(int stamp, int r0, int r1, int i0, int i1);
    exp_t e;
    e.stamp = stamp; e.re0 = r0; e.re1 = r1; e.im0 = i0; e.im1 = i1;
    q.push_back(e);
  endfunction

  function automatic void compute_v();
    int dr, di, vr, vi;
    for (int l = 0; l < ARRAY; l++) begin
      for (int m = 0; m < H; m++) begin
        dr = xr[l][m] - xr[l][m+H];
        di = xi[l][m] - xi[l][m+H];
        if (m >= H/2 && f_inv) begin vr = -di; vi = dr; end
        else if (m >= H/2)     begin vr = di;  vi = -dr; end
        else                   begin vr = dr;  vi = di; end
        pvr[l][m] = f_scl ? half_up(vr) : vr;
        pvi[l][m] = f_scl ? half_up(vi) : vi;
      end
    end
  endfunction

  function automatic void model_beat(int stamp, int r0, int i0, int r1, int i1, bit inv, bit scl);
    int ur[ARRAY], ui[ARRAY];
    if (j == 0) begin f_inv = inv; f_scl = scl; end
    xr[0][j] = r0; xr[1][j] = r1;
    xi[0][j] = i0; xi[1][j] = i1;
    if (j < H) begin
      if (pend) push_exp(stamp, pvr[0][j], pvr[1][j], pvi[0][j], pvi[1][j]);
      if (j == H-1) pend = 0;
    end else begin
      for (int l = 0; l < ARRAY; l++) begin
        ur[l] = xr[l][j-H] + xr[l][j];
        ui[l] = xi[l][j-H] + xi[l][j];
        if (f_scl) begin ur[l] = half_up(ur[l]); ui[l] = half_up(ui[l]); end
      end
      push_exp(stamp, ur[0], ur[1], ui[0], ui[1]);
      if (j == 2*H-1) begin compute_v(); pend = 1; end
    end
    j = (j + 1) % (2*H);
  endfunction

  // Monitor: independent of the driver, compares every presented beat with the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      while (q.size() > 0 && q[0].stamp < edge_cnt) begin
        checks++; errors++;
        $display("FAIL missing_out actual=none required=beat due at edge %0d", q[0].stamp);
        void'(q.pop_front());
      end
      if (valid_out === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out actual=valid_out 1 required=no beat (edge %0d)", edge_cnt);
        end else begin
          e = q.pop_front();
          check("out_cycle", edge_cnt, e.stamp);
          check("out_re0", sx(dout_re[W-1:0]),   e.re0);
          check("out_re1", sx(dout_re[2*W-1:W]), e.re1);
          check("out_im0", sx(dout_im[W-1:0]),   e.im0);
          check("out_im1", sx(dout_im[2*W-1:W]), e.im1);
        end
      end
    end
  end

  task automatic scramble();
    din_re = (DATA*ARRAY)'($urandom());
    din_im = (DATA*ARRAY)'($urandom());
  endtask

  task automatic send(int r0, int i0, bit inv, bit scl);
    int r1, i1;
    r1 = neg_sat(r0);
    i1 = neg_sat(i0);
    valid_in = 1'b1; flush_req = 1'b0; mode_inv = inv; scale_en = scl;
    din_re = {DATA'(r1), DATA'(r0)};
    din_im = {DATA'(i1), DATA'(i0)};
    model_beat(edge_cnt + 2, r0, i0, r1, i1, inv, scl);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(int n, bit fl);
    valid_in = 1'b0; flush_req = fl; scramble();
    repeat (n) @(negedge clk);
    flush_req = 1'b0;
  endtask

  task automatic quiet_check(string tag);
    idle(3, 1'b0);
    check({tag, "_pending"},  pending,  pend);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_err_drop"}, err_drop, exp_err);
  endtask

  task automatic flush(bit with_valid);
    int e0;
    e0 = edge_cnt;
    flush_req = 1'b1; valid_in = with_valid; scramble();
    if (with_valid) exp_err = 1;
    @(negedge clk);
    flush_req = 1'b0; valid_in = 1'b0;
    for (int k = 0; k < H; k++)
      push_exp(e0 + 3 + k, pvr[0][k], pvr[1][k], pvi[0][k], pvi[1][k]);
    pend = 0;
    for (int k = 0; k < H; k++) begin
      check("flush_in_ready", in_ready, 0);
      valid_in = with_valid && (k == 1);
      @(negedge clk);
      valid_in = 1'b0;
    end
    check("flush_end_in_ready", in_ready, 1);
  endtask

  task automatic frame_ramp(bit inv, bit scl, bit gapped);
    for (int k = 1; k <= 2*H; k++) begin
      send(k, 0, inv, scl);
      if (gapped) idle(1, k < 2*H);
    end
  endtask

  task automatic frame_zero(bit gapped);
    for (int k = 0; k < 2*H; k++) begin
      send(0, 0, 1'b0, 1'b0);
      if (gapped) idle(1, 1'b0);
    end
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_pending"},   pending,   0);
    check({tag, "_err_drop"},  err_drop,  0);
    check({tag, "_dout_re"},   dout_re,   0);
    check({tag, "_dout_im"},   dout_im,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs toggling
    rstn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      valid_in = 1'($urandom()); flush_req = 1'($urandom());
      mode_inv = 1'($urandom()); scale_en = 1'($urandom()); scramble();
      #1 check_zero_outputs("reset");
    end
    valid_in = 1'b0; flush_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Forward, unscaled ramp, then zeros to push out the v-half
    frame_ramp(1'b0, 1'b0, 1'b0);
    quiet_check("after_ramp");
    frame_zero(1'b0);

    // Inverse twiddle, followed by a forward frame: v keeps its own frame's direction
    frame_ramp(1'b1, 1'b0, 1'b0);
    frame_zero(1'b0);

    // Scaled ramp, then extremes -256 vs 255 scaled
    frame_ramp(1'b0, 1'b1, 1'b0);
    frame_zero(1'b0);
    for (int k = 0; k < 2*H; k++) send((k < H) ? -256 : 255, (k < H) ? 255 : -256, 1'b0, 1'b1);
    frame_zero(1'b0);

    // Flush drain, then flush with dropped beats
    quiet_check("pre_flush");
    flush(1'b0);
    quiet_check("post_flush");
    idle(1, 1'b1);
    check("flush_ignored_ready", in_ready, 1);
    frame_ramp(1'b0, 1'b0, 1'b0);
    flush(1'b1);
    quiet_check("post_flush_drop");

    // Gapped input with ignored flush requests in the gaps
    frame_ramp(1'b0, 1'b0, 1'b1);
    frame_zero(1'b1);
    quiet_check("after_gapped");

    // Reset in the middle of S_B
    for (int k = 1; k <= H + 2; k++) send(k, k, 1'b0, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_zero_outputs("mid_reset");
    q.delete(); j = 0; pend = 0; exp_err = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_mid_reset", in_ready, 1);
    frame_ramp(1'b0, 1'b0, 1'b0);
    frame_zero(1'b0);

    // Randomised frames, gaps, settings and flushes
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 2*H; k++) begin
        send(int'($urandom_range(511, 0)) - 256, int'($urandom_range(511, 0)) - 256,
             1'($urandom()), 1'($urandom()));
        if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(2, 1)), (j != 0));
      end
      if ($urandom_range(2, 0) == 0) flush(1'($urandom()));
    end
    quiet_check("final");
    idle(8, 1'b0);
    check("drain_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
